// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer arbiter slice.
//   SER_DATA_W / SER_MOD_W : serializer word and length-code widths
//   mod_is_legal()         : length code 0 (16 bits) or 3..15 is accepted
//   mod_to_len()           : bit count carried by a length code
//   arb_state_t            : arbiter FSM states
package serializer_pkg;

  localparam int SER_DATA_W = 16;
  localparam int SER_MOD_W  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Codes 1 and 2 would ask for a 1- or 2-bit word, which the serializer
  // cannot frame, so they are refused.
  function automatic logic mod_is_legal(input logic [SER_MOD_W-1:0] mod);
    return (mod == '0) || (mod >= SER_MOD_W'(3));
  endfunction

  // Code 0 stands for the full 16-bit word.
  function automatic logic [4:0] mod_to_len(input logic [SER_MOD_W-1:0] mod);
    return (mod == '0) ? 5'd16 : {1'b0, mod};
  endfunction

endpackage

// File: rtl/serializer_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker.
//   req     : request vector, one bit per requester
//   ptr     : index holding highest priority this cycle
//   grant   : one-hot winner (zero when no request)
//   idx     : winner index (0 when no request)
//   any_req : at least one request present
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  // cand[k] is the requester index examined at priority rank k, i.e.
  // (ptr + k) mod N_REQ. The extra sum bit keeps the wrap exact for
  // non-power-of-two N_REQ.
  logic [IDX_W-1:0] cand [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum >= (IDX_W+1)'(N_REQ))
                        ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                        : sum[IDX_W-1:0];
    end
  endgenerate

  // Walk from lowest priority up so the highest-priority hit is written last.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[cand[off]]) begin
        grant            = '0;
        grant[cand[off]] = 1'b1;
        idx              = cand[off];
        any_req          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// serializer_arbiter: shares one serializer between N_REQ requesters.
//   clk_i, srst_i          : clock, synchronous active-high reset
//   req_data_i/req_mod_i   : per-requester word and length code
//   req_val_i/req_ready_o  : per-requester handshake (ready one-hot or zero)
//   ser_data_o/ser_mod_o   : word and length code presented to the serializer
//   ser_val_o              : one-cycle issue strobe
//   ser_busy_i             : serializer busy flag
//   grant_id_o             : index of the current/last granted requester
//   arb_busy_o             : high whenever the FSM is not IDLE
//   drop_o                 : pulse after an illegal length code was discarded
//   err_o                  : pulse when the serializer failed to raise busy
module serializer_arbiter
  import serializer_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = SER_DATA_W,
  parameter int MOD_W  = SER_MOD_W,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [N_REQ-1:0][DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0][MOD_W-1:0]  req_mod_i,
  input  logic [N_REQ-1:0]             req_val_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic [DATA_W-1:0]            ser_data_o,
  output logic [MOD_W-1:0]             ser_mod_o,
  output logic                         ser_val_o,
  input  logic                         ser_busy_i,
  output logic [IDX_W-1:0]             grant_id_o,
  output logic                         arb_busy_o,
  output logic                         drop_o,
  output logic                         err_o
);

  arb_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg;
  logic [IDX_W-1:0]  ptr_next;
  logic [N_REQ-1:0]  win_grant;
  logic [IDX_W-1:0]  win_idx;
  logic              any_req;
  logic              win_legal;
  logic              handshake;

  logic [DATA_W-1:0] ser_data_reg;
  logic [MOD_W-1:0]  ser_mod_reg;
  logic [IDX_W-1:0]  grant_id_reg;
  logic              drop_reg;
  logic              err_reg;

  rr_grant #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_grant (
    .req     (req_val_i),
    .ptr     (ptr_reg),
    .grant   (win_grant),
    .idx     (win_idx),
    .any_req (any_req)
  );

  assign win_legal = mod_is_legal(req_mod_i[win_idx]);
  // The winner always has val set, so ready on the winner implies val&ready.
  assign handshake = (state_reg == IDLE) && any_req;
  assign ptr_next  = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(win_idx + 1'b1);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_ready_o = '0;
    ser_val_o   = 1'b0;
    arb_busy_o  = 1'b1;
    case (state_reg)
      IDLE: begin
        arb_busy_o  = 1'b0;
        req_ready_o = win_grant;
        // Illegal codes are consumed but keep the FSM in IDLE.
        if (handshake && win_legal) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ser_val_o  = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        state_next = ser_busy_i ? WAIT_DONE : IDLE;
      end
      WAIT_DONE: begin
        if (!ser_busy_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ptr_reg      <= '0;
      ser_data_reg <= '0;
      ser_mod_reg  <= '0;
      grant_id_reg <= '0;
      drop_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      drop_reg <= handshake && !win_legal;
      err_reg  <= (state_reg == WAIT_BUSY) && !ser_busy_i;
      if (handshake) begin
        ptr_reg <= ptr_next;
        if (win_legal) begin
          ser_data_reg <= req_data_i[win_idx];
          ser_mod_reg  <= req_mod_i[win_idx];
          grant_id_reg <= win_idx;
        end
      end
    end
  end

  assign ser_data_o = ser_data_reg;
  assign ser_mod_o  = ser_mod_reg;
  assign grant_id_o = grant_id_reg;
  assign drop_o     = drop_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Self-checking bench for serializer_arbiter (N_REQ = 4) with a behavioural
// MSB-first serializer model driving ser_busy_i.
module tb_serializer_arbiter;

  logic             clk = 1'b0;
  logic             srst = 1'b1;
  logic [3:0][15:0] req_data = '0;
  logic [3:0][3:0]  req_mod = '0;
  logic [3:0]       req_val = '0;
  logic [3:0]       req_ready;
  logic [15:0]      ser_data;
  logic [3:0]       ser_mod;
  logic             ser_val;
  logic             ser_busy;
  logic [1:0]       grant_id;
  logic             arb_busy;
  logic             drop;
  logic             err;

  int n_vec  = 0;
  int n_miss = 0;

  serializer_arbiter #(.N_REQ(4)) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .req_data_i  (req_data),
    .req_mod_i   (req_mod),
    .req_val_i   (req_val),
    .req_ready_o (req_ready),
    .ser_data_o  (ser_data),
    .ser_mod_o   (ser_mod),
    .ser_val_o   (ser_val),
    .ser_busy_i  (ser_busy),
    .grant_id_o  (grant_id),
    .arb_busy_o  (arb_busy),
    .drop_o      (drop),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Serializer model: busy rises the cycle after the strobe and stays high
  // for one cycle per emitted bit; the captured word is right-aligned.
  logic        no_busy = 1'b0;
  logic [15:0] sh;
  logic [4:0]  scnt;
  logic [15:0] cap;
  logic [15:0] wq[$];

  always @(posedge clk) begin
    if (srst) begin
      ser_busy <= 1'b0;
      scnt     <= '0;
    end else if (ser_busy) begin
      cap  <= {cap[14:0], sh[15]};
      sh   <= {sh[14:0], 1'b0};
      scnt <= 5'(scnt - 5'd1);
      if (scnt == 5'd1) begin
        ser_busy <= 1'b0;
        wq.push_back({cap[14:0], sh[15]});
      end
    end else if (ser_val && !no_busy) begin
      sh       <= ser_data;
      scnt     <= (ser_mod == 4'd0) ? 5'd16 : {1'b0, ser_mod};
      ser_busy <= 1'b1;
      cap      <= '0;
    end
  end

  // Transaction monitor.
  logic [1:0]  gq[$];
  logic [15:0] dq[$];
  logic [3:0]  mq[$];
  int drops, errs, overlap, gapviol, idle_run;
  bit prev_busy, seen_fall;

  always @(negedge clk) begin
    if (!srst) begin
      if (ser_val) begin
        gq.push_back(grant_id);
        dq.push_back(ser_data);
        mq.push_back(ser_mod);
        if (ser_busy) overlap++;
        $display("issue: grant %0d data %h mod %0d", grant_id, ser_data, ser_mod);
      end
      if (drop) drops++;
      if (err) errs++;
      if (ser_busy) begin
        if (!prev_busy && seen_fall && idle_run < 2) gapviol++;
        idle_run = 0;
      end else begin
        if (prev_busy) seen_fall = 1'b1;
        idle_run++;
      end
      prev_busy = ser_busy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    gq.delete(); dq.delete(); mq.delete(); wq.delete();
    drops = 0; errs = 0; overlap = 0; gapviol = 0; idle_run = 0;
    prev_busy = 1'b0; seen_fall = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b1; req_val = '0; req_data = '0; req_mod = '0; no_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_idle(input int lim, input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (!arb_busy && !ser_busy) begin ok = 1'b1; break; end
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  function automatic logic [15:0] exp_bits(input logic [15:0] d, input logic [3:0] m);
    int len;
    len = (m == 4'd0) ? 16 : int'(m);
    return d >> (16 - len);
  endfunction

  typedef struct {
    logic [3:0][3:0]  cnt;    // handshakes each requester makes
    logic [3:0][3:0]  mod;
    logic [3:0][15:0] data;
    int               n_issue;
    logic [3:0][1:0]  order;  // order[k] = requester of the k-th issue
    int               n_drop;
  } vec_t;

  vec_t tab [5];

  task automatic run_vec(input int v);
    logic [3:0][3:0] cnt;
    logic [3:0]      hs;
    int              rem;
    bit              done;
    logic [1:0]      r;
    do_reset();
    req_data = tab[v].data;
    req_mod  = tab[v].mod;
    cnt      = tab[v].cnt;
    for (int i = 0; i < 4; i++) req_val[i] = (cnt[i] != 4'd0);
    done = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      hs  = req_ready & req_val;
      rem = 0;
      for (int i = 0; i < 4; i++) rem += int'(cnt[i]);
      if (rem == 0 && !arb_busy && !ser_busy) begin done = 1'b1; break; end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          cnt[i] = 4'(cnt[i] - 4'd1);
          if (cnt[i] == 4'd0) req_val[i] = 1'b0;
        end
      end
    end
    check($sformatf("v%0d_done", v), 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_issues", v), 32'(gq.size()), 32'(tab[v].n_issue));
    check($sformatf("v%0d_words", v), 32'(wq.size()), 32'(tab[v].n_issue));
    for (int k = 0; k < tab[v].n_issue; k++) begin
      r = tab[v].order[k];
      if (k < gq.size()) begin
        check($sformatf("v%0d_grant%0d", v, k), 32'(gq[k]), 32'(r));
        check($sformatf("v%0d_data%0d", v, k), 32'(dq[k]), 32'(tab[v].data[r]));
        check($sformatf("v%0d_mod%0d", v, k), 32'(mq[k]), 32'(tab[v].mod[r]));
      end
      if (k < wq.size())
        check($sformatf("v%0d_bits%0d", v, k), 32'(wq[k]),
              32'(exp_bits(tab[v].data[r], tab[v].mod[r])));
    end
    check($sformatf("v%0d_drops", v), 32'(drops), 32'(tab[v].n_drop));
    check($sformatf("v%0d_errs", v), 32'(errs), 32'd0);
    check($sformatf("v%0d_overlap", v), 32'(overlap), 32'd0);
    check($sformatf("v%0d_gap", v), 32'(gapviol), 32'd0);
    $display("vector %0d: %0d issues, %0d drops", v, gq.size(), drops);
  endtask

  initial begin
    // {req3, req2, req1, req0}
    tab[0].cnt = {4'd0, 4'd0, 4'd0, 4'd1};   tab[0].mod = {4'd0, 4'd0, 4'd0, 4'd0};
    tab[0].data = {16'h0, 16'h0, 16'h0, 16'hA5C3};
    tab[0].n_issue = 1; tab[0].order = {2'd0, 2'd0, 2'd0, 2'd0}; tab[0].n_drop = 0;

    tab[1].cnt = {4'd2, 4'd0, 4'd2, 4'd0};   tab[1].mod = {4'd4, 4'd0, 4'd4, 4'd0};
    tab[1].data = {16'h6FFF, 16'h0, 16'hB000, 16'h0};
    tab[1].n_issue = 4; tab[1].order = {2'd3, 2'd1, 2'd3, 2'd1}; tab[1].n_drop = 0;

    tab[2].cnt = {4'd1, 4'd1, 4'd1, 4'd1};   tab[2].mod = {4'd15, 4'd0, 4'd5, 4'd3};
    tab[2].data = {16'hFFFE, 16'h1234, 16'h5A5A, 16'hE000};
    tab[2].n_issue = 4; tab[2].order = {2'd3, 2'd2, 2'd1, 2'd0}; tab[2].n_drop = 0;

    tab[3].cnt = {4'd0, 4'd0, 4'd1, 4'd1};   tab[3].mod = {4'd0, 4'd0, 4'd6, 4'd1};
    tab[3].data = {16'h0, 16'h0, 16'hC3C3, 16'hFFFF};
    tab[3].n_issue = 1; tab[3].order = {2'd0, 2'd0, 2'd0, 2'd1}; tab[3].n_drop = 1;

    tab[4].cnt = {4'd1, 4'd1, 4'd0, 4'd0};   tab[4].mod = {4'd0, 4'd0, 4'd0, 4'd0};
    tab[4].data = {16'h8001, 16'h7FFE, 16'h0, 16'h0};
    tab[4].n_issue = 2; tab[4].order = {2'd0, 2'd0, 2'd3, 2'd2}; tab[4].n_drop = 0;

    clear_logs();

    // Reset values.
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_ser_val", 32'(ser_val), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_data", 32'(ser_data), 32'd0);
    check("rst_mod", 32'(ser_mod), 32'd0);

    // Latency: handshake at T, strobe at T+1, busy at T+2.
    do_reset();
    req_data[0] = 16'hA5C3; req_mod[0] = 4'd0; req_val = 4'b0001;
    @(negedge clk);
    check("lat_ready_T", 32'(req_ready), 32'b0001);
    check("lat_val_T", 32'(ser_val), 32'd0);
    @(posedge clk); #1 req_val = '0;
    @(negedge clk);
    check("lat_val_T1", 32'(ser_val), 32'd1);
    check("lat_data_T1", 32'(ser_data), 32'hA5C3);
    check("lat_busy_T1", 32'(arb_busy), 32'd1);
    @(negedge clk);
    check("lat_serbusy_T2", 32'(ser_busy), 32'd1);
    check("lat_val_T2", 32'(ser_val), 32'd0);
    wait_idle(40, "lat_idle");
    check("lat_grant_hold", 32'(grant_id), 32'd0);
    check("lat_data_hold", 32'(ser_data), 32'hA5C3);
    check("lat_nwords", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) check("lat_bits", 32'(wq[0]), 32'hA5C3);

    // Illegal length code: dropped, pointer moves past requester 2.
    do_reset();
    req_mod[2] = 4'd2; req_val = 4'b0100;
    @(negedge clk);
    check("drop_ready_T", 32'(req_ready), 32'b0100);
    check("drop_pulse_T", 32'(drop), 32'd0);
    @(posedge clk); #1 req_mod = '0; req_val = 4'b1001;
    @(negedge clk);
    check("drop_pulse_T1", 32'(drop), 32'd1);
    check("drop_ser_val", 32'(ser_val), 32'd0);
    check("drop_ptr3", 32'(req_ready), 32'b1000);
    req_val = '0;
    @(negedge clk);
    check("drop_pulse_T2", 32'(drop), 32'd0);
    check("drop_arb_busy", 32'(arb_busy), 32'd0);
    check("drop_no_issue", 32'(gq.size()), 32'd0);

    // Reset during WAIT_DONE of a 16-bit transfer.
    do_reset();
    req_data[1] = 16'hFFFF; req_val = 4'b0010;
    @(negedge clk);
    check("rstmid_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1 req_val = '0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (ser_busy) begin seen = 1'b1; break; end
      end
      check("rstmid_busy_seen", 32'(seen), 32'd1);
    end
    repeat (3) @(negedge clk);
    check("rstmid_inflight", 32'(arb_busy), 32'd1);
    @(posedge clk); #1 srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0; req_val = 4'b0101;
    @(negedge clk);
    check("rstmid_arb_busy", 32'(arb_busy), 32'd0);
    check("rstmid_ser_val", 32'(ser_val), 32'd0);
    check("rstmid_grant", 32'(grant_id), 32'd0);
    check("rstmid_data", 32'(ser_data), 32'd0);
    check("rstmid_mod", 32'(ser_mod), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    check("rstmid_ptr0", 32'(req_ready), 32'b0001);
    req_val = '0;

    // Serializer never raises busy: err pulse, then next requester served.
    do_reset();
    no_busy = 1'b1;
    req_data[0] = 16'h1111; req_data[1] = 16'h2222; req_val = 4'b0011;
    @(negedge clk);
    check("err_ready_T", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 req_val = 4'b0010;
    @(negedge clk);
    check("err_issue", 32'(ser_val), 32'd1);
    check("err_ready_issue", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("err_wait_busy", 32'(arb_busy), 32'd1);
    check("err_not_yet", 32'(err), 32'd0);
    @(negedge clk);
    check("err_pulse", 32'(err), 32'd1);
    check("err_idle", 32'(arb_busy), 32'd0);
    check("err_next_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1 req_val = '0;
    @(negedge clk);
    check("err_pulse_once", 32'(err), 32'd0);
    check("err_next_issue", 32'(ser_val), 32'd1);
    check("err_next_grant", 32'(grant_id), 32'd1);
    check("err_next_data", 32'(ser_data), 32'h2222);
    repeat (4) @(negedge clk);
    check("err_count", 32'(errs), 32'd2);
    no_busy = 1'b0;

    // Table-driven arbitration scenarios.
    for (int v = 0; v < 5; v++) run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
